ghr_ckpt: RTL and testbench
===========================

GHR_CKPT -- requirements
Module: ghr_ckpt

Interface
REQ-001 SHALL have parameter GHR_SIZE, default 9, global history length in bits (>=2).
REQ-002 SHALL have parameter FETCH_W, default 2, branch slots per fetch group (1..4).
REQ-003 SHALL have parameter CKPT_DEPTH, default 8, checkpoint entries (power of 2, >=FETCH_W).
REQ-004 SHALL have port CLK  in  1  single clock, all state on posedge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port fetch_valid  in  1  fetch group presented this cycle.
REQ-007 SHALL have port pred_branch  in  FETCH_W  slot i holds a predicted branch; slot 0 oldest.
REQ-008 SHALL have port pred_taken  in  FETCH_W  predicted direction per slot.
REQ-009 SHALL have port fetch_ready  out  1  group accepted this cycle.
REQ-010 SHALL have port ckpt_id  out  FETCH_W*log2(CKPT_DEPTH)  checkpoint id per slot, valid when slot is a live branch.
REQ-011 SHALL have port commit_valid  in  1  oldest checkpoint retires.
REQ-012 SHALL have port restore_valid  in  1  mispredict recovery request.
REQ-013 SHALL have port restore_id  in  log2(CKPT_DEPTH)  checkpoint of the mispredicted branch.
REQ-014 SHALL have port actual_taken  in  1  resolved direction of that branch.
REQ-015 SHALL have port ghr_out  out  GHR_SIZE  registered history.
REQ-016 SHALL have port ckpt_count  out  log2(CKPT_DEPTH)+1  live entries.
REQ-017 SHALL have ports ckpt_full, ckpt_empty  out  1 each  count==CKPT_DEPTH / count==0.

Function
REQ-018 SHALL treat slot i as live iff pred_branch[i] and no older slot j<i has pred_branch[j]&pred_taken[j]; live slots after the first predicted-taken branch are discarded.
REQ-019 SHALL compute n_live = number of live slots; fetch_ready = !restore_valid && (CKPT_DEPTH - ckpt_count + commit_valid) >= n_live, combinationally.
REQ-020 SHALL, on fetch_valid && fetch_ready, shift ghr_out left once per live slot in slot order inserting pred_taken, all in one cycle (result visible next cycle).
REQ-021 SHALL write, for each live slot, the history seen by that branch (before its own bit) into entry tail+k, k = rank among live slots, and drive ckpt_id for that slot = tail+k mod CKPT_DEPTH, same cycle.
REQ-022 SHALL advance tail by n_live on acceptance; n_live==0 or fetch_valid low leaves GHR and pointers unchanged.
REQ-023 SHALL, on commit_valid with ckpt_empty low, advance head by 1; commit_valid on empty is ignored.
REQ-024 SHALL, on restore_valid, load ghr_out <= {ckpt[restore_id][GHR_SIZE-2:0], actual_taken} and set tail <= restore_id+1, squashing all younger entries.
REQ-025 SHALL keep head/tail with one extra wrap bit; ckpt_count = tail-head modulo 2*CKPT_DEPTH; wrap-around of ids SHALL be seamless.
REQ-026 SHALL apply commit and restore in the same cycle independently (head+1, tail=restore_id+1); if restore_id==head the resulting count is 0.
REQ-027 SHALL give priority reset > restore > fetch; fetch is never accepted during restore.
REQ-028 SHALL never overwrite a live entry; full blocks any group with n_live>0 unless a commit frees enough space that cycle.

Reset
REQ-029 SHALL, on reset, set ghr_out=0, head=tail=0, ckpt_count=0, ckpt_empty=1, ckpt_full=0; checkpoint storage contents need no reset.
REQ-030 SHALL let reset override concurrent restore, commit and fetch in that cycle.

Structure
REQ-031 SHALL place GHR_SIZE, CKPT_DEPTH defaults and ckpt-id typedef in the shared core package.
REQ-032 SHALL implement checkpoint storage as sub-module ghr_ckpt_ram (FETCH_W write ports, one async read port).

Verification
REQ-033 SHALL test: reset, group pred_branch=2'b11 pred_taken=2'b00 -> ghr_out=9'b000000000, ids 0,1, count=2.
REQ-034 SHALL test: ghr=9'h0FF, pred_branch=2'b11 pred_taken=2'b01 -> only slot0 live, ghr=9'h1FF, count+1.
REQ-035 SHALL test: fill to 8 entries, present 1 branch without commit -> fetch_ready=0, ghr unchanged; add commit_valid -> accepted.
REQ-036 SHALL test: entries 2..6 live, restore_id=4 with stored history 9'h0A5, actual_taken=1 -> ghr=9'h14B, tail=5, count=3.
REQ-037 SHALL test: restore_valid and commit_valid together with restore_id==head -> count=0, ckpt_empty=1.
REQ-038 SHALL test: 20 single-branch alloc/commit pairs -> ids wrap 7->0 correctly, count never exceeds 8.

Source files
------------

// File: rtl/ghr_ckpt_pkg.sv
// Shared core package for the global-history checkpoint block:
// default sizes and the checkpoint-id type used by the core and its benches.
package ghr_ckpt_pkg;

  localparam int GHR_SIZE_DEF   = 9;
  localparam int FETCH_W_DEF    = 2;
  localparam int CKPT_DEPTH_DEF = 8;
  localparam int CKPT_ID_W      = $clog2(CKPT_DEPTH_DEF);

  // Index of one checkpoint entry at the default depth.
  typedef logic [CKPT_ID_W-1:0] ckpt_id_t;

endpackage

// File: rtl/ghr_ckpt_ram.sv
// Checkpoint storage: NWP synchronous write ports, one asynchronous read port.
// Only the low history bits are stored, because a restore shifts the top
// bit out and never needs it.
module ghr_ckpt_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int NWP   = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic [NWP-1:0]     we,
  input  logic [NWP*AW-1:0]  waddr,
  input  logic [NWP*DW-1:0]  wdata,
  input  logic [AW-1:0]      raddr,
  output logic [DW-1:0]      rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write every enabled port; the allocator never aims two ports at one entry.
  // NOTE: storage is deliberately left without reset -- entries are only read
  // after being written, and a reset here would block RAM inference.
  always_ff @(posedge CLK) begin
    for (int p = 0; p < NWP; p++) begin
      if (we[p]) begin
        mem[waddr[p*AW +: AW]] <= wdata[p*DW +: DW];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ghr_ckpt.sv
// Global history register with per-branch checkpoints for mispredict recovery.
// A fetch group shifts in the directions of its live branches and records,
// per branch, the history that branch saw; a restore rebuilds the history
// from the mispredicted branch's checkpoint plus its resolved direction.
module ghr_ckpt
  import ghr_ckpt_pkg::*;
#(
  parameter int GHR_SIZE   = GHR_SIZE_DEF,
  parameter int FETCH_W    = FETCH_W_DEF,
  parameter int CKPT_DEPTH = CKPT_DEPTH_DEF,
  localparam int IDW       = $clog2(CKPT_DEPTH),
  localparam int CW        = IDW + 1
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   fetch_valid,
  input  logic [FETCH_W-1:0]     pred_branch,
  input  logic [FETCH_W-1:0]     pred_taken,
  output logic                   fetch_ready,
  output logic [FETCH_W*IDW-1:0] ckpt_id,
  input  logic                   commit_valid,
  input  logic                   restore_valid,
  input  logic [IDW-1:0]         restore_id,
  input  logic                   actual_taken,
  output logic [GHR_SIZE-1:0]    ghr_out,
  output logic [CW-1:0]          ckpt_count,
  output logic                   ckpt_full,
  output logic                   ckpt_empty
);

  // head/tail carry one wrap bit so full and empty are distinguishable.
  logic [CW-1:0]         head_q, tail_q;
  logic [GHR_SIZE-1:0]   ghr_q;

  logic [FETCH_W-1:0]    live;
  logic [IDW-1:0]        rank [FETCH_W];
  logic [GHR_SIZE-2:0]   hist [FETCH_W];
  logic [GHR_SIZE-1:0]   ghr_fetch;
  logic [CW-1:0]         n_live;
  logic [CW:0]           free_slots;
  logic                  accept;
  logic                  commit_fire;
  logic [IDW-1:0]        restore_off;
  logic [CW-1:0]         tail_restore;
  logic [GHR_SIZE-2:0]   ckpt_rdata;

  logic [FETCH_W-1:0]          ram_we;
  logic [FETCH_W*IDW-1:0]      ram_waddr;
  logic [FETCH_W*(GHR_SIZE-1)-1:0] ram_wdata;

  // Walk the slots oldest first: mark live branches, rank them, and build
  // the history each one sees plus the history after the whole group.
  always_comb begin
    logic                blocked;
    logic [GHR_SIZE-1:0] h;
    logic [CW-1:0]       k;
    // NOTE: these locals are combinational scratch carried across loop
    // iterations, so they use blocking assignments and get a value first.
    blocked = 1'b0;
    h       = ghr_q;
    k       = '0;
    live    = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      rank[i] = k[IDW-1:0];
      hist[i] = h[GHR_SIZE-2:0];
      if (pred_branch[i] && !blocked) begin
        live[i] = 1'b1;
        h       = {h[GHR_SIZE-2:0], pred_taken[i]};
        k       = k + CW'(1);
        if (pred_taken[i]) blocked = 1'b1;
      end
    end
    n_live    = k;
    ghr_fetch = h;
  end

  assign ckpt_count  = tail_q - head_q;
  assign ckpt_empty  = (ckpt_count == '0);
  assign ckpt_full   = (ckpt_count == CW'(CKPT_DEPTH));
  assign commit_fire = commit_valid && !ckpt_empty;

  // Space check counts an entry retiring this same cycle as free.
  assign free_slots  = (CW+1)'(CKPT_DEPTH) - {1'b0, ckpt_count}
                     + {{CW{1'b0}}, commit_valid};
  assign fetch_ready = !restore_valid && (free_slots >= {1'b0, n_live});
  assign accept      = fetch_valid && fetch_ready;

  // The restored tail keeps the right wrap bit by offsetting from head.
  assign restore_off  = restore_id - head_q[IDW-1:0];
  assign tail_restore = head_q + {1'b0, restore_off} + CW'(1);

  // Per-slot checkpoint ids and RAM write ports for the live branches.
  always_comb begin
    ckpt_id   = '0;
    ram_we    = '0;
    ram_waddr = '0;
    ram_wdata = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      ckpt_id[i*IDW +: IDW]   = tail_q[IDW-1:0] + rank[i];
      ram_we[i]               = accept && live[i];
      ram_waddr[i*IDW +: IDW] = tail_q[IDW-1:0] + rank[i];
      ram_wdata[i*(GHR_SIZE-1) +: (GHR_SIZE-1)] = hist[i];
    end
  end

  ghr_ckpt_ram #(
    .DW    (GHR_SIZE - 1),
    .DEPTH (CKPT_DEPTH),
    .NWP   (FETCH_W),
    .AW    (IDW)
  ) u_ram (
    .CLK   (CLK),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (restore_id),
    .rdata (ckpt_rdata)
  );

  // History and pointer state: reset > restore > fetch; commit is independent.
  // NOTE: all architectural state updates use non-blocking assignments so
  // every register samples the pre-edge values.
  always_ff @(posedge CLK) begin
    if (reset) begin
      ghr_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (commit_fire) begin
        head_q <= head_q + CW'(1);
      end
      if (restore_valid) begin
        ghr_q  <= {ckpt_rdata, actual_taken};
        tail_q <= tail_restore;
      end else if (accept) begin
        ghr_q  <= ghr_fetch;
        tail_q <= tail_q + n_live;
      end
    end
  end

  assign ghr_out = ghr_q;

endmodule

// File: tb/tb_ghr_ckpt.sv
// Directed bench for ghr_ckpt: hand-computed histories, ids and counts.
`timescale 1ns/1ps
module tb_ghr_ckpt;
  import ghr_ckpt_pkg::*;

  localparam int GS = 9;
  localparam int FW = 2;
  localparam int CD = 8;
  localparam int IW = 3;

  logic          CLK;
  logic          reset;
  logic          fetch_valid;
  logic [FW-1:0] pred_branch;
  logic [FW-1:0] pred_taken;
  logic          fetch_ready;
  logic [FW*IW-1:0] ckpt_id;
  logic          commit_valid;
  logic          restore_valid;
  logic [IW-1:0] restore_id;
  logic          actual_taken;
  logic [GS-1:0] ghr_out;
  logic [IW:0]   ckpt_count;
  logic          ckpt_full;
  logic          ckpt_empty;

  int n_checks = 0;
  int n_fail   = 0;

  ghr_ckpt #(.GHR_SIZE(GS), .FETCH_W(FW), .CKPT_DEPTH(CD)) dut (
    .CLK           (CLK),
    .reset         (reset),
    .fetch_valid   (fetch_valid),
    .pred_branch   (pred_branch),
    .pred_taken    (pred_taken),
    .fetch_ready   (fetch_ready),
    .ckpt_id       (ckpt_id),
    .commit_valid  (commit_valid),
    .restore_valid (restore_valid),
    .restore_id    (restore_id),
    .actual_taken  (actual_taken),
    .ghr_out       (ghr_out),
    .ckpt_count    (ckpt_count),
    .ckpt_full     (ckpt_full),
    .ckpt_empty    (ckpt_empty)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic ckpt_id_t slot_id(input int s);
    return ckpt_id[s*IW +: IW];
  endfunction

  // Inputs change just after the falling edge; combinational outputs settle by #1.
  task automatic drive(input logic fv, input logic [1:0] pb, input logic [1:0] pt,
                       input logic cv, input logic rv, input logic [2:0] rid,
                       input logic at);
    fetch_valid   = fv;
    pred_branch   = pb;
    pred_taken    = pt;
    commit_valid  = cv;
    restore_valid = rv;
    restore_id    = rid;
    actual_taken  = at;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    drive(0, 2'b00, 2'b00, 0, 0, 3'd0, 0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic bits12 [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    reset = 1'b1;
    drive(0, 2'b00, 2'b00, 0, 0, 3'd0, 0);

    // Reset state, with a restore/commit/fetch held during reset.
    @(negedge CLK);
    drive(1, 2'b01, 2'b01, 1, 1, 3'd3, 1);
    tick();
    drive(0, 2'b00, 2'b00, 0, 0, 3'd0, 0);
    reset = 1'b0;
    check("rst_ghr",   ghr_out,    9'h000);
    check("rst_count", ckpt_count, 4'd0);
    check("rst_empty", ckpt_empty, 1'b1);
    check("rst_full",  ckpt_full,  1'b0);

    // Two not-taken branches: ids 0,1, history stays zero.
    drive(1, 2'b11, 2'b00, 0, 0, 3'd0, 0);
    check("g1_ready", fetch_ready, 1'b1);
    check("g1_id0",   slot_id(0),  3'd0);
    check("g1_id1",   slot_id(1),  3'd1);
    tick();
    check("g1_ghr",   ghr_out,    9'h000);
    check("g1_count", ckpt_count, 4'd2);
    check("g1_empty", ckpt_empty, 1'b0);

    // Build ghr=0x0FF from eight taken branches, committing each cycle
    // (first commit lands on empty and is ignored).
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 2'b01, 2'b01, 1, 0, 3'd0, 0);
      tick();
    end
    check("ff_ghr",   ghr_out,    9'h0FF);
    check("ff_count", ckpt_count, 4'd1);
    // Slot 0 taken squashes slot 1; id wraps from tail 8 to 0.
    drive(1, 2'b11, 2'b01, 0, 0, 3'd0, 0);
    check("tk_id0", slot_id(0), 3'd0);
    tick();
    check("tk_ghr",   ghr_out,    9'h1FF);
    check("tk_count", ckpt_count, 4'd2);

    // Fill to eight entries, then a blocked fetch, then one freed by commit.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'b11, 2'b00, 0, 0, 3'd0, 0);
      tick();
    end
    check("full_count", ckpt_count, 4'd8);
    check("full_flag",  ckpt_full,  1'b1);
    drive(1, 2'b01, 2'b01, 0, 0, 3'd0, 0);
    check("full_block", fetch_ready, 1'b0);
    tick();
    check("full_ghr_hold", ghr_out,    9'h000);
    check("full_cnt_hold", ckpt_count, 4'd8);
    drive(1, 2'b01, 2'b01, 1, 0, 3'd0, 0);
    check("full_cmt_ready", fetch_ready, 1'b1);
    check("full_cmt_id",    slot_id(0),  3'd0);
    tick();
    check("full_cmt_ghr",   ghr_out,    9'h001);
    check("full_cmt_count", ckpt_count, 4'd8);
    // Fetch with no branches leaves everything unchanged.
    drive(1, 2'b00, 2'b11, 0, 0, 3'd0, 0);
    tick();
    check("nobr_ghr",   ghr_out,    9'h001);
    check("nobr_count", ckpt_count, 4'd8);

    // Twelve single branches; commits from the third on leave head at
    // abs 10 (id 2), tail at abs 12 (id 4), ghr=0x0A5.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1, 2'b01, {1'b0, bits12[i]}, (i >= 2), 0, 3'd0, 0);
      tick();
    end
    check("a5_ghr",   ghr_out,    9'h0A5);
    check("a5_count", ckpt_count, 4'd2);
    drive(1, 2'b11, 2'b00, 0, 0, 3'd0, 0);
    check("a5_id0", slot_id(0), 3'd4);
    check("a5_id1", slot_id(1), 3'd5);
    tick();
    drive(1, 2'b01, 2'b00, 0, 0, 3'd0, 0);
    check("a5_id6", slot_id(0), 3'd6);
    tick();
    check("live26_count", ckpt_count, 4'd5);
    // Restore to id 4 (history 0x0A5), actual taken.
    drive(1, 2'b01, 2'b00, 0, 1, 3'd4, 1);
    check("rs_ready", fetch_ready, 1'b0);
    tick();
    check("rs_ghr",   ghr_out,    9'h14B);
    check("rs_count", ckpt_count, 4'd3);
    drive(0, 2'b01, 2'b00, 0, 0, 3'd0, 0);
    check("rs_tail_id", slot_id(0), 3'd5);

    // Restore at head together with commit: everything squashed.
    // Entry 2 holds 0x029, so ghr becomes {0x29[7:0],0} = 0x052.
    drive(0, 2'b00, 2'b00, 1, 1, 3'd2, 0);
    tick();
    check("rh_count", ckpt_count, 4'd0);
    check("rh_empty", ckpt_empty, 1'b1);
    check("rh_ghr",   ghr_out,    9'h052);

    // Twenty alloc/commit pairs: ids run 0..7 and wrap.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1, 2'b01, {1'b0, i[0]}, 0, 0, 3'd0, 0);
      check($sformatf("wrap_id_%0d", i), slot_id(0), i % 8);
      tick();
      check($sformatf("wrap_cnt_%0d", i), ckpt_count, 4'd1);
      check($sformatf("wrap_le8_%0d", i), (ckpt_count <= 4'd8), 1'b1);
      drive(0, 2'b00, 2'b00, 1, 0, 3'd0, 0);
      tick();
      check($sformatf("wrap_cmt_%0d", i), ckpt_count, 4'd0);
    end
    check("wrap_ghr", ghr_out, 9'h155);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
